ca_fitness_evaluator: RTL and testbench

Downstream consumer of a binary cellular automaton stage. On a start pulse it drives the automaton's clock-enable for a fixed number of generations. Each generation it samples the automaton state, computes its population count and accumulates a saturating fitness score. It also records the fittest single generation, then presents the result on a valid/ready handshake to the migration or selection logic.

---
 rtl/ca_fitness_evaluator.sv | 94 +++++++++
 tb/tb_ca_fitness_evaluator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ca_fitness_evaluator.sv
// Fitness evaluator for a binary cellular automaton: runs the automaton for a
// fixed number of generations, accumulates a saturating popcount score and tracks the fittest state.
module ca_fitness_evaluator #(
  parameter int Width       = 16,
  parameter int Generations = 10,
  parameter int CountWidth  = 5,
  parameter int AccWidth    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Width-1:0]      state,
  output logic                  ce_out,
  output logic                  busy,
  output logic                  valid,
  input  logic                  ready,
  output logic [AccWidth-1:0]   fitness,
  output logic [Width-1:0]      best,
  output logic [CountWidth-1:0] best_ones
);

  localparam int GenWidth = (Generations > 1) ? $clog2(Generations) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } st_t;

  st_t                  st;
  st_t                  st_nx;
  logic [GenWidth-1:0]  gen;
  logic [CountWidth-1:0] p;
  logic [AccWidth:0]    sum;
  logic                 last;

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      p = p + CountWidth'(state[i]);
    end
  end

  // one extra bit catches the carry out for the saturating clamp
  assign sum  = {1'b0, fitness} + (AccWidth+1)'(p);
  assign last = (gen == GenWidth'(Generations - 1));

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (start) st_nx = RUN;
      RUN:     if (last)  st_nx = HOLD;
      HOLD:    if (ready) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // decoded straight from the state register, so reset drops them at once
  assign ce_out = (st == RUN);
  assign busy   = (st != IDLE);
  assign valid  = (st == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      gen       <= '0;
      fitness   <= '0;
      best      <= '0;
      best_ones <= '0;
    end else begin
      st <= st_nx;
      case (st)
        IDLE: begin
          if (start) begin
            gen       <= '0;
            fitness   <= '0;
            best      <= '0;
            best_ones <= '0;
          end
        end
        RUN: begin
          fitness <= sum[AccWidth] ? '1 : sum[AccWidth-1:0];
          if (p > best_ones) begin
            best      <= state;
            best_ones <= p;
          end
          gen <= gen + GenWidth'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_fitness_evaluator.sv
// Bench for ca_fitness_evaluator: cycle-checked default instance plus
// directed runs on a 3-generation instance and a 7-bit accumulator instance.
module tb_ca_fitness_evaluator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_m = 1'b0, start_g = 1'b0, start_a = 1'b0;
  logic ready = 1'b1;
  logic [15:0] state = 16'h0;

  logic        ce_m, busy_m, valid_m;
  logic [7:0]  fit_m;
  logic [15:0] best_m;
  logic [4:0]  ones_m;
  logic        ce_g, busy_g, valid_g;
  logic [7:0]  fit_g;
  logic [15:0] best_g;
  logic [4:0]  ones_g;
  logic        ce_a, busy_a, valid_a;
  logic [6:0]  fit_a;
  logic [15:0] best_a;
  logic [4:0]  ones_a;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] pat [10];

  always #5 clk = ~clk;

  ca_fitness_evaluator #(.Width(16), .Generations(10), .CountWidth(5), .AccWidth(8)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .state(state), .ce_out(ce_m), .busy(busy_m),
    .valid(valid_m), .ready(ready), .fitness(fit_m), .best(best_m), .best_ones(ones_m));

  ca_fitness_evaluator #(.Width(16), .Generations(3), .CountWidth(5), .AccWidth(8)) u_g3 (
    .clk(clk), .rst(rst), .start(start_g), .state(state), .ce_out(ce_g), .busy(busy_g),
    .valid(valid_g), .ready(ready), .fitness(fit_g), .best(best_g), .best_ones(ones_g));

  ca_fitness_evaluator #(.Width(16), .Generations(10), .CountWidth(5), .AccWidth(7)) u_a7 (
    .clk(clk), .rst(rst), .start(start_a), .state(state), .ce_out(ce_a), .busy(busy_a),
    .valid(valid_a), .ready(ready), .fitness(fit_a), .best(best_a), .best_ones(ones_a));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the default instance: phase 0 idle, 1 run, 2 hold; results come
  // from the list of states sampled in the current run.
  int mphase = 0;
  logic [15:0] samp [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mphase = 0;
      samp.delete();
    end else begin
      case (mphase)
        0: if (start_m) begin mphase = 1; samp.delete(); end
        1: begin
          samp.push_back(state);
          if (samp.size() == 10) mphase = 2;
        end
        default: if (ready) mphase = 0;
      endcase
    end
  end

  function automatic int exp_fit();
    int s = 0;
    foreach (samp[i]) s += $countones(samp[i]);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int exp_ones();
    int b = 0;
    foreach (samp[i]) if ($countones(samp[i]) > b) b = $countones(samp[i]);
    return b;
  endfunction

  function automatic logic [15:0] exp_best();
    int b = 0;
    logic [15:0] r = 16'h0;
    foreach (samp[i]) if ($countones(samp[i]) > b) begin b = $countones(samp[i]); r = samp[i]; end
    return r;
  endfunction

  always @(negedge clk) begin
    chk("m_ce_out", 32'(ce_m),    32'(mphase == 1));
    chk("m_busy",   32'(busy_m),  32'(mphase != 0));
    chk("m_valid",  32'(valid_m), 32'(mphase == 2));
    chk("m_fitness", 32'(fit_m),  32'(exp_fit()));
    chk("m_best",   32'(best_m),  32'(exp_best()));
    chk("m_best_ones", 32'(ones_m), 32'(exp_ones()));
  end

  task automatic run(input int sel, output int ce_cnt, output int v_cnt,
                     output logic [31:0] f, output logic [31:0] b, output logic [31:0] o);
    ce_cnt = 0; v_cnt = 0; f = 0; b = 0; o = 0;
    @(negedge clk);
    case (sel)
      0: start_m = 1'b1;
      1: start_g = 1'b1;
      default: start_a = 1'b1;
    endcase
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      start_m = 1'b0; start_g = 1'b0; start_a = 1'b0;
      case (sel)
        0: begin
          if (ce_m) ce_cnt++;
          if (valid_m) begin v_cnt++; f = 32'(fit_m); b = 32'(best_m); o = 32'(ones_m); end
        end
        1: begin
          if (ce_g) ce_cnt++;
          if (valid_g) begin v_cnt++; f = 32'(fit_g); b = 32'(best_g); o = 32'(ones_g); end
        end
        default: begin
          if (ce_a) ce_cnt++;
          if (valid_a) begin v_cnt++; f = 32'(fit_a); b = 32'(best_a); o = 32'(ones_a); end
        end
      endcase
      state = (k < 10) ? pat[k] : 16'h0;
    end
  endtask

  initial begin
    int ce_cnt, v_cnt;
    logic [31:0] f, b, o;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_fitness", 32'(fit_m), 32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // all ones, ready high
    foreach (pat[i]) pat[i] = 16'hFFFF;
    run(0, ce_cnt, v_cnt, f, b, o);
    chk("ffff_ce_cycles", 32'(ce_cnt), 32'd10);
    chk("ffff_valid_cycles", 32'(v_cnt), 32'd1);
    chk("ffff_fitness", f, 32'd160);
    chk("ffff_best", b, 32'hFFFF);
    chk("ffff_best_ones", o, 32'd16);

    // all zeros still produces a result
    foreach (pat[i]) pat[i] = 16'h0000;
    run(0, ce_cnt, v_cnt, f, b, o);
    chk("zero_valid_cycles", 32'(v_cnt), 32'd1);
    chk("zero_fitness", f, 32'd0);
    chk("zero_best", b, 32'h0);
    chk("zero_best_ones", o, 32'd0);

    // rising popcounts 1..10
    foreach (pat[i]) pat[i] = 16'((32'd1 << (i + 1)) - 1);
    run(0, ce_cnt, v_cnt, f, b, o);
    chk("ramp_fitness", f, 32'd55);
    chk("ramp_best", b, 32'h03FF);
    chk("ramp_best_ones", o, 32'd10);

    // backpressure: single-bit states tie on popcount, earliest wins
    ready = 1'b0;
    foreach (pat[i]) pat[i] = 16'(32'd1 << i);
    run(0, ce_cnt, v_cnt, f, b, o);
    chk("bp_valid_cycles", 32'(v_cnt), 32'd4);
    for (int k = 0; k < 5; k++) begin
      start_m = (k == 2);
      @(negedge clk);
      chk("bp_valid_held", 32'(valid_m), 32'd1);
      chk("bp_fitness_held", 32'(fit_m), 32'd10);
      chk("bp_best_held", 32'(best_m), 32'h0001);
      chk("bp_ones_held", 32'(ones_m), 32'd1);
    end
    ready = 1'b1;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    chk("bp_release_valid", 32'(valid_m), 32'd0);
    chk("bp_release_busy", 32'(busy_m), 32'd0);
    foreach (pat[i]) pat[i] = 16'h0101;
    run(0, ce_cnt, v_cnt, f, b, o);
    chk("fresh_fitness", f, 32'd20);

    // reset in the 4th RUN cycle
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    state = 16'hFFFF;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ce", 32'(ce_m), 32'd0);
    chk("midrst_busy", 32'(busy_m), 32'd0);
    chk("midrst_valid", 32'(valid_m), 32'd0);
    chk("midrst_fitness", 32'(fit_m), 32'd0);
    chk("midrst_best", 32'(best_m), 32'd0);
    chk("midrst_ones", 32'(ones_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy_m), 32'd0);
    foreach (pat[i]) pat[i] = 16'hFFFF;
    run(0, ce_cnt, v_cnt, f, b, o);
    chk("post_rst_fitness", f, 32'd160);
    chk("post_rst_valid_cycles", 32'(v_cnt), 32'd1);

    // three generations, tie keeps earliest
    foreach (pat[i]) pat[i] = 16'h0;
    pat[0] = 16'h0007; pat[1] = 16'h001F; pat[2] = 16'h03E0;
    run(1, ce_cnt, v_cnt, f, b, o);
    chk("g3_ce_cycles", 32'(ce_cnt), 32'd3);
    chk("g3_valid_cycles", 32'(v_cnt), 32'd1);
    chk("g3_fitness", f, 32'd13);
    chk("g3_best", b, 32'h001F);
    chk("g3_best_ones", o, 32'd5);

    // 7-bit accumulator saturates
    foreach (pat[i]) pat[i] = 16'hFFFF;
    run(2, ce_cnt, v_cnt, f, b, o);
    chk("a7_valid_cycles", 32'(v_cnt), 32'd1);
    chk("a7_fitness", f, 32'd127);
    chk("a7_best", b, 32'hFFFF);
    chk("a7_best_ones", o, 32'd16);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
